hilo_mdu_ctrl: RTL and testbench

Multiply/divide sequencer and owner of the architectural HI/LO pair. It accepts MDU ops (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO) from the decode stage and runs multiplies with a fixed latency and divides iteratively. It stalls decode while a result is pending, then drives one write-back cycle onto the decode stage's HI/LO write ports (HIWrite/HI_in, LOWrite/LO data).

---
 rtl/hilo_mdu_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_hilo_mdu_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl: multiply/divide sequencer that owns the architectural HI/LO pair.
// Multiplies complete after a fixed MUL_LAT. Divides use a 32-step restoring loop.
// Results leave through a single registered write-back cycle.
// Build option: define MDU_DIV_EN to include the iterative divider. Without it,
// DIV/DIVU are accepted in IDLE as no-ops.
module hilo_mdu_ctrl #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic        busy,
  output logic        HIWrite,
  output logic        LOWrite,
  output logic [31:0] HI_in,
  output logic [31:0] LO_in,
  output logic [31:0] mf_data
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  localparam logic [CW-1:0] MUL_LAST = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [CW-1:0] DIV_LAST = CW'(31);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_WB} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [W-1:0]  hi_q, lo_q;
  logic [2*W-1:0] prod_q;

  logic          wb_load, wb_hi, wb_lo;
  logic [W-1:0]  wb_hi_data, wb_lo_data;
  logic          prod_load;

  logic [2*W-1:0] mul_a, mul_b, prod;

  // Sign- or zero-extend the operands so a single 64-bit multiplier serves both forms.
  assign mul_a = (op == OP_MULT) ? {{W{rs_val[W-1]}}, rs_val} : {{W{1'b0}}, rs_val};
  assign mul_b = (op == OP_MULT) ? {{W{rt_val[W-1]}}, rt_val} : {{W{1'b0}}, rt_val};
  assign prod  = mul_a * mul_b;

  assign stall   = op_valid && busy;
  assign mf_data = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : '0;

`ifdef MDU_DIV_EN
  logic          div_start;
  logic [W-1:0]  div_rem, div_quo, div_dvs, div_rs;
  logic          div_qneg, div_rneg, div_zero;
  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    rem_sh;
  logic          rem_ge;
  logic [W-1:0]  rem_new, quo_new, q_fin, r_fin;

  // Operand magnitudes for the unsigned core; only DIV is treated as signed.
  assign a_neg = (op == OP_DIV) && rs_val[W-1];
  assign b_neg = (op == OP_DIV) && rt_val[W-1];
  assign a_mag = a_neg ? -rs_val : rs_val;
  assign b_mag = b_neg ? -rt_val : rt_val;

  // One restoring step: shift in the next dividend bit and subtract when possible.
  assign rem_sh  = {div_rem, div_quo[W-1]};
  assign rem_ge  = (rem_sh >= {1'b0, div_dvs});
  assign rem_new = rem_ge ? W'(rem_sh - {1'b0, div_dvs}) : rem_sh[W-1:0];
  assign quo_new = {div_quo[W-2:0], rem_ge};

  // Sign fix-up, plus the fixed divide-by-zero result.
  always_comb begin
    q_fin = div_qneg ? -quo_new : quo_new;
    r_fin = div_rneg ? -rem_new : rem_new;
    if (div_zero) begin
      q_fin = '1;
      r_fin = div_rs;
    end
  end

  // Divider working registers, loaded at accept and stepped once per DIV cycle.
  always_ff @(posedge clk) begin
    if (div_start) begin
      div_rem  <= '0;
      div_quo  <= a_mag;
      div_dvs  <= b_mag;
      div_rs   <= rs_val;
      div_qneg <= a_neg ^ b_neg;
      div_rneg <= a_neg;
      div_zero <= (rt_val == '0);
    end else if (state == S_DIV) begin
      div_rem <= rem_new;
      div_quo <= quo_new;
    end
  end
`endif

  // Next-state and write-back selection.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    wb_load    = 1'b0;
    wb_hi      = 1'b0;
    wb_lo      = 1'b0;
    wb_hi_data = '0;
    wb_lo_data = '0;
    prod_load  = 1'b0;
`ifdef MDU_DIV_EN
    div_start  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (op_valid) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              if (MUL_LAT <= 1) begin
                wb_load    = 1'b1;
                wb_hi      = 1'b1;
                wb_lo      = 1'b1;
                wb_hi_data = prod[2*W-1:W];
                wb_lo_data = prod[W-1:0];
                state_next = S_WB;
              end else begin
                prod_load  = 1'b1;
                cnt_next   = '0;
                state_next = S_MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
`ifdef MDU_DIV_EN
              div_start  = 1'b1;
              cnt_next   = '0;
              state_next = S_DIV;
`endif
            end
            OP_MTHI: begin
              wb_load    = 1'b1;
              wb_hi      = 1'b1;
              wb_hi_data = rs_val;
              state_next = S_WB;
            end
            OP_MTLO: begin
              wb_load    = 1'b1;
              wb_lo      = 1'b1;
              wb_lo_data = rs_val;
              state_next = S_WB;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        cnt_next = cnt + CW'(1);
        if (cnt == MUL_LAST) begin
          wb_load    = 1'b1;
          wb_hi      = 1'b1;
          wb_lo      = 1'b1;
          wb_hi_data = prod_q[2*W-1:W];
          wb_lo_data = prod_q[W-1:0];
          state_next = S_WB;
        end
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        cnt_next = cnt + CW'(1);
        if (cnt == DIV_LAST) begin
          wb_load    = 1'b1;
          wb_hi      = 1'b1;
          wb_lo      = 1'b1;
          wb_hi_data = r_fin;
          wb_lo_data = q_fin;
          state_next = S_WB;
        end
      end
`endif
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Product captured at accept so the operands may change while MUL counts down.
  always_ff @(posedge clk) begin
    if (prod_load) prod_q <= prod;
  end

  // State, registered outputs and the architectural HI/LO pair.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      HIWrite <= 1'b0;
      LOWrite <= 1'b0;
      HI_in   <= '0;
      LO_in   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      busy    <= (state_next != S_IDLE);
      HIWrite <= wb_load && wb_hi;
      LOWrite <= wb_load && wb_lo;
      if (wb_load && wb_hi) HI_in <= wb_hi_data;
      if (wb_load && wb_lo) LO_in <= wb_lo_data;
      if (state == S_WB) begin
        if (HIWrite) hi_q <= HI_in;
        if (LOWrite) lo_q <= LO_in;
      end
    end
  end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: stimulus pushes expected write-backs,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_hilo_mdu_ctrl;

  localparam int unsigned MUL_LAT = 3;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  logic        clk = 1'b0;
  logic        CLR;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        stall, busy, HIWrite, LOWrite;
  logic [31:0] HI_in, LO_in, mf_data;

  typedef struct {
    logic        hiw;
    logic        low;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hilo_mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .CLR(CLR), .op_valid(op_valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .HI_in(HI_in), .LO_in(LO_in),
    .mf_data(mf_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wb(input logic hiw, input logic low, input logic [31:0] hi,
                           input logic [31:0] lo, input int c);
    exp_t e;
    e.hiw = hiw; e.low = low; e.hi = hi; e.lo = lo; e.cyc = c;
    sb.push_back(e);
  endtask

  // Present an op (called #1 after a rising edge), wait out any stall, let it be accepted.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit chk_mf, input logic [31:0] exp_mf, output int acc_cyc);
    int guard;
    guard    = 0;
    op_valid = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    #1;
    while (busy && guard < 100) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: op %0d still stalled after %0d cycles", o, guard);
    end
    check("stall_when_idle", 32'(stall), 32'd0);
    if (chk_mf) check("mf_data", mf_data, exp_mf);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    op_valid = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest pending expectation, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!CLR && (HIWrite || LOWrite)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got hiw=%b low=%b hi=%h lo=%h at cycle %0d, none required",
                 HIWrite, LOWrite, HI_in, LO_in, cyc);
      end else begin
        e = sb.pop_front();
        if (HIWrite !== e.hiw || LOWrite !== e.low || HI_in !== e.hi ||
            LO_in !== e.lo || cyc != e.cyc) begin
          miscompares++;
          $display("FAIL wb: got hiw=%b low=%b hi=%h lo=%h cyc=%0d, expected hiw=%b low=%b hi=%h lo=%h cyc=%0d",
                   HIWrite, LOWrite, HI_in, LO_in, cyc, e.hiw, e.low, e.hi, e.lo, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    CLR      = 1'b1;
    op_valid = 1'b0;
    op       = OP_MFHI;
    rs_val   = '0;
    rt_val   = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_stall",   32'(stall),   32'd0);
    check("rst_hiwrite", 32'(HIWrite), 32'd0);
    check("rst_lowrite", 32'(LOWrite), 32'd0);
    check("rst_hi_in",   HI_in,        32'd0);
    check("rst_lo_in",   LO_in,        32'd0);
    check("rst_mfhi",    mf_data,      32'd0);
    op = OP_MFLO; #0;
    check("rst_mflo",    mf_data,      32'd0);
    CLR = 1'b0;
    @(posedge clk); #1;

    // MULT -2 * 3, busy for MUL_LAT cycles
    issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, acc + MUL_LAT - 1);
    check("mult_busy0", 32'(busy), 32'd1);
    @(posedge clk); #1; check("mult_busy1", 32'(busy), 32'd1);
    @(posedge clk); #1; check("mult_busy2", 32'(busy), 32'd1);
    @(posedge clk); #1; check("mult_idle",  32'(busy), 32'd0);

    // MULTU followed at once by a stalled MFHI
    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFE, acc + MUL_LAT - 1);
    op_valid = 1'b1; op = OP_MFHI; #1;
    check("mfhi_stall", 32'(stall), 32'd1);
    issue(OP_MFHI, 32'd0, 32'd0, 1'b1, 32'h00000001, acc);

    // MTLO writes LO only; HI_in keeps its last value
    issue(OP_MTLO, 32'h00001234, 32'd0, 1'b0, 32'd0, acc);
    expect_wb(1'b0, 1'b1, 32'h00000001, 32'h00001234, acc);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b1, 32'h00001234, acc);
    issue(OP_MFHI, 32'd0, 32'd0, 1'b1, 32'h00000001, acc);

    // MTHI writes HI only
    issue(OP_MTHI, 32'h0000CAFE, 32'd0, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b0, 32'h0000CAFE, 32'h00001234, acc);
    issue(OP_MFHI, 32'd0, 32'd0, 1'b1, 32'h0000CAFE, acc);

    // MULTU max * max
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001, acc + MUL_LAT - 1);

`ifdef MDU_DIV_EN
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, acc + 32);
    issue(OP_DIVU, 32'd100, 32'd0, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'd100, 32'hFFFFFFFF, acc + 32);
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'h00000000, 32'h80000000, acc + 32);
    issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFD, acc + 32);
    issue(OP_DIV, 32'hFFFFFFF0, 32'd0, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'hFFFFFFF0, 32'hFFFFFFFF, acc + 32);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, acc);
    issue(OP_MFHI, 32'd0, 32'd0, 1'b1, 32'hFFFFFFF0, acc);

    // CLR in the tenth DIV cycle discards the result
    issue(OP_DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, acc);
    repeat (9) begin @(posedge clk); #1; end
    CLR = 1'b1;
    @(posedge clk); #1;
    CLR = 1'b0;
    check("clr_div_busy", 32'(busy), 32'd0);
    issue(OP_MFHI, 32'd0, 32'd0, 1'b1, 32'd0, acc);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b1, 32'd0, acc);
`else
    // Without the divider, DIVU is a silent no-op in IDLE
    issue(OP_DIVU, 32'd9, 32'd3, 1'b0, 32'd0, acc);
    check("divu_noop_busy", 32'(busy), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    issue(OP_MFHI, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFE, acc);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b1, 32'h00000001, acc);
`endif

    // CLR mid-MULT, then a fresh MULT is accepted immediately
    issue(OP_MULT, 32'd5, 32'd6, 1'b0, 32'd0, acc);
    CLR = 1'b1;
    @(posedge clk); #1;
    CLR = 1'b0;
    check("clr_mul_busy", 32'(busy), 32'd0);
    check("clr_mul_hiw",  32'(HIWrite), 32'd0);
    issue(OP_MFHI, 32'd0, 32'd0, 1'b1, 32'd0, acc);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b1, 32'd0, acc);
    issue(OP_MULT, 32'd5, 32'hFFFFFFFA, 1'b0, 32'd0, acc);
    expect_wb(1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFE2, acc + MUL_LAT - 1);
    issue(OP_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFFFFE2, acc);

    guard = 0;
    while (busy && guard < 100) begin @(posedge clk); #1; guard++; end
    repeat (3) @(posedge clk);
    #1;
    check("pending_wb_left", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
